// File: rtl/snr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// snr_sweep_ctrl - steps noise sigma through a sweep; per point: flush, settle,
// count bit errors over a fixed window, report one record.   Rev 1.0
// ============================================================================
module snr_sweep_ctrl #(
  parameter int NBT_SIGMA  = 8,
  parameter int FLUSH_CYC  = 16,
  parameter int SETTLE_SYM = 64,
  parameter int MEAS_SYM   = 4096,
  parameter int NB_ERRCNT  = 16,
  parameter int NB_NPTS    = 4
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NBT_SIGMA-1:0] i_sigma_start,
  input  logic [NBT_SIGMA-1:0] i_sigma_step,
  input  logic [NB_NPTS-1:0]   i_n_points,
  input  logic                 i_sym_valid,
  input  logic                 i_bit_err,
  input  logic                 i_res_ready,
  output logic [NBT_SIGMA-1:0] o_sigma,
  output logic                 o_dp_enable,
  output logic                 o_dp_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_res_valid,
  output logic [NBT_SIGMA-1:0] o_res_sigma,
  output logic [NB_ERRCNT-1:0] o_res_errs
);

  localparam int MAX_FS  = (FLUSH_CYC > SETTLE_SYM) ? FLUSH_CYC : SETTLE_SYM;
  localparam int MAX_CNT = (MAX_FS > MEAS_SYM) ? MAX_FS : MEAS_SYM;
  localparam int NB_CNT  = $clog2(MAX_CNT + 1);

  localparam logic [NB_CNT-1:0]    CNT_ONE     = NB_CNT'(1);
  localparam logic [NB_CNT-1:0]    FLUSH_LAST  = NB_CNT'(FLUSH_CYC - 1);
  localparam logic [NB_CNT-1:0]    SETTLE_LAST = NB_CNT'(SETTLE_SYM - 1);
  localparam logic [NB_CNT-1:0]    MEAS_LAST   = NB_CNT'(MEAS_SYM - 1);
  localparam logic [NB_ERRCNT-1:0] ERR_ONE     = NB_ERRCNT'(1);
  localparam logic [NB_NPTS-1:0]   PTS_ONE     = NB_NPTS'(1);
  localparam logic [NBT_SIGMA-1:0] SIG_MAX     = {1'b0, {(NBT_SIGMA-1){1'b1}}};
  localparam logic [NBT_SIGMA-1:0] SIG_MIN     = {1'b1, {(NBT_SIGMA-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SETTLE = 3'd2,
    S_MEAS   = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [NB_CNT-1:0]     cnt_q, cnt_d;
  logic [NB_ERRCNT-1:0]  err_q, err_d;
  logic [NBT_SIGMA-1:0]  sigma_q, sigma_d;
  logic [NBT_SIGMA-1:0]  step_q, step_d;
  logic [NB_NPTS-1:0]    last_q, last_d;
  logic [NB_NPTS-1:0]    idx_q, idx_d;

  logic [NBT_SIGMA:0]    sigma_sum;
  logic [NBT_SIGMA-1:0]  sigma_next;

  // Sign-extended add; a mismatch of the top two bits means overflow.
  always_comb begin
    sigma_sum  = {sigma_q[NBT_SIGMA-1], sigma_q} + {step_q[NBT_SIGMA-1], step_q};
    sigma_next = sigma_sum[NBT_SIGMA-1:0];
    if (sigma_sum[NBT_SIGMA] != sigma_sum[NBT_SIGMA-1]) begin
      sigma_next = sigma_sum[NBT_SIGMA] ? SIG_MIN : SIG_MAX;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      sigma_q <= '0;
      step_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sigma_q <= sigma_d;
      step_q  <= step_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    sigma_d     = sigma_q;
    step_d      = step_q;
    last_d      = last_q;
    idx_d       = idx_q;
    o_dp_enable = 1'b0;
    o_dp_flush  = 1'b0;
    o_done      = 1'b0;
    o_res_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sigma_d = i_sigma_start;
          step_d  = i_sigma_step;
          last_d  = (i_n_points == '0) ? '0 : (i_n_points - PTS_ONE);
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        o_dp_flush = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SETTLE: begin
        o_dp_enable = 1'b1;
        if (i_sym_valid) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_MEAS;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_MEAS: begin
        o_dp_enable = 1'b1;
        if (i_sym_valid) begin
          if (i_bit_err && (err_q != '1)) begin
            err_d = err_q + ERR_ONE;
          end
          // The final strobe of the window is counted before leaving.
          if (cnt_q == MEAS_LAST) begin
            cnt_d   = '0;
            state_d = S_REPORT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_REPORT: begin
        o_res_valid = 1'b1;
        if (i_res_ready) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            sigma_d = sigma_next;
            idx_d   = idx_q + PTS_ONE;
            err_d   = '0;
            state_d = S_FLUSH;
          end
        end
      end

      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_sigma     = sigma_q;
  assign o_res_sigma = sigma_q;
  assign o_res_errs  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_snr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_snr_sweep_ctrl - vector table of sweeps with a record scoreboard, plus
// backpressure, start-while-busy and async-reset sequences.   Rev 1.0
// ============================================================================
module tb_snr_sweep_ctrl;

  localparam int B_FLUSH  = 4;
  localparam int B_SETTLE = 8;
  localparam int B_MEAS   = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, sym_valid, bit_err, res_ready;
  logic [7:0]  sig_start, sig_step;
  logic [3:0]  n_pts;

  logic [7:0]  sigma_a, rs_a, sigma_b, rs_b;
  logic        en_a, fl_a, busy_a, done_a, rv_a;
  logic        en_b, fl_b, busy_b, done_b, rv_b;
  logic [15:0] re_a;
  logic [7:0]  re_b;

  snr_sweep_ctrl dut_a (
    .clk(clk), .i_reset(rst), .i_start(start_a),
    .i_sigma_start(sig_start), .i_sigma_step(sig_step), .i_n_points(n_pts),
    .i_sym_valid(sym_valid), .i_bit_err(bit_err), .i_res_ready(res_ready),
    .o_sigma(sigma_a), .o_dp_enable(en_a), .o_dp_flush(fl_a), .o_busy(busy_a),
    .o_done(done_a), .o_res_valid(rv_a), .o_res_sigma(rs_a), .o_res_errs(re_a)
  );

  snr_sweep_ctrl #(
    .FLUSH_CYC(B_FLUSH), .SETTLE_SYM(B_SETTLE), .MEAS_SYM(B_MEAS), .NB_ERRCNT(8)
  ) dut_b (
    .clk(clk), .i_reset(rst), .i_start(start_b),
    .i_sigma_start(sig_start), .i_sigma_step(sig_step), .i_n_points(n_pts),
    .i_sym_valid(sym_valid), .i_bit_err(bit_err), .i_res_ready(res_ready),
    .o_sigma(sigma_b), .o_dp_enable(en_b), .o_dp_flush(fl_b), .o_busy(busy_b),
    .o_done(done_b), .o_res_valid(rv_b), .o_res_sigma(rs_b), .o_res_errs(re_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Baud strobe every strobe_per clocks; error flag on every err_every-th strobe.
  int strobe_per = 1;
  int err_every  = 0;
  int ph         = 0;
  int scnt       = 0;
  always @(negedge clk) begin
    if (ph >= strobe_per - 1) begin
      ph = 0;
      scnt++;
      sym_valid = 1'b1;
      bit_err   = (err_every != 0) && ((scnt % err_every) == 0);
    end else begin
      ph++;
      sym_valid = 1'b0;
      bit_err   = 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0]  sig;
    logic [15:0] errs;
  } rec_t;

  rec_t q_a[$];
  rec_t q_b[$];
  rec_t ea, eb;
  int recs_a = 0, recs_b = 0, dones_a = 0, dones_b = 0;
  int busy_cyc = 0, fl_run = 0;

  // Monitor samples 1 ns before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (rv_a && res_ready) begin
        recs_a++;
        if (q_a.size() == 0) begin
          chk("a_record_expected", q_a.size(), 1);
        end else begin
          ea = q_a.pop_front();
          chk("a_res_sigma", rs_a, ea.sig);
          chk("a_res_errs", re_a, ea.errs);
          chk("a_enable_in_report", en_a, 0);
        end
      end
      if (rv_b && res_ready) begin
        recs_b++;
        if (q_b.size() == 0) begin
          chk("b_record_expected", q_b.size(), 1);
        end else begin
          eb = q_b.pop_front();
          chk("b_res_sigma", rs_b, eb.sig);
          chk("b_res_errs", re_b, eb.errs);
        end
      end
      if (done_a) dones_a++;
      if (done_b) dones_b++;
      if (busy_a) busy_cyc++;
      if (fl_a) begin
        fl_run++;
        if (en_a) chk("a_enable_in_flush", en_a, 0);
      end else if (fl_run != 0) begin
        chk("a_flush_len", fl_run, 16);
        fl_run = 0;
      end
    end
  end

  typedef struct packed {
    logic [7:0]       s0;
    logic [7:0]       step;
    logic [3:0]       n;
    int               per;
    int               every;
    logic             on_b;
    logic             bp;
    logic             poke;
    int               exp_n;
    logic [3:0][7:0]  exp_sig;
    logic [15:0]      exp_errs;
  } vec_t;

  vec_t vecs [6];

  task automatic do_poke();
    repeat (16 + 64 * 2 + 100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      #4;
      if (done_a) begin
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_bp(input int r0);
    logic [7:0]  cap_s;
    logic [15:0] cap_e;
    logic        stable, seen;
    for (int c = 0; c < 60000 && recs_a < r0 + 1; c++) @(negedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      #4;
      if (rv_a) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_report_reached", seen, 1);
    cap_s  = rs_a;
    cap_e  = re_a;
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      #4;
      if (!rv_a || rs_a !== cap_s || re_a !== cap_e || en_a) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    @(negedge clk);
    res_ready = 1'b1;
  endtask

  task automatic run_sweep(input vec_t v, input string tag);
    int   lim, d0, r0;
    logic to;
    @(negedge clk);
    strobe_per = v.per;
    err_every  = v.every;
    sig_start  = v.s0;
    sig_step   = v.step;
    n_pts      = v.n;
    res_ready  = 1'b1;
    d0 = v.on_b ? dones_b : dones_a;
    r0 = v.on_b ? recs_b : recs_a;
    for (int i = 0; i < v.exp_n; i++) begin
      if (v.on_b) q_b.push_back({v.exp_sig[i], v.exp_errs});
      else        q_a.push_back({v.exp_sig[i], v.exp_errs});
    end
    busy_cyc = 0;
    if (v.on_b) start_b = 1'b1;
    else        start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lim = v.on_b ? v.exp_n * (B_FLUSH + (B_SETTLE + B_MEAS) * v.per + 10) + 300
                 : v.exp_n * (16 + (64 + 4096) * v.per + 10) + 300;
    to = 1'b1;
    fork
      begin
        if (v.poke) do_poke();
      end
      begin
        if (v.bp) do_bp(r0);
      end
      begin
        for (int c = 0; c < lim; c++) begin
          @(negedge clk);
          #4;
          if (!(v.on_b ? busy_b : busy_a)) begin
            to = 1'b0;
            break;
          end
        end
      end
    join
    chk({tag, "_timeout"}, to, 0);
    repeat (3) @(negedge clk);
    #4;
    chk({tag, "_no_restart"}, v.on_b ? busy_b : busy_a, 0);
    chk({tag, "_done_pulses"}, (v.on_b ? dones_b : dones_a) - d0, 1);
    chk({tag, "_records"}, (v.on_b ? recs_b : recs_a) - r0, v.exp_n);
    chk({tag, "_queue_empty"}, v.on_b ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    //          s0     step   n     per every b     bp    poke  n  exp_sig[3..0]  errs
    vecs[0] = '{8'h1C, 8'h04, 4'd1, 4, 0, 1'b0, 1'b0, 1'b0, 1, 32'h0000_001C, 16'd0};
    vecs[1] = '{8'h1C, 8'h04, 4'd3, 2, 8, 1'b0, 1'b1, 1'b1, 3, 32'h0024_201C, 16'd512};
    vecs[2] = '{8'h7C, 8'h08, 4'd2, 1, 1, 1'b1, 1'b0, 1'b0, 2, 32'h0000_7F7C, 16'd255};
    vecs[3] = '{8'hE0, 8'hF0, 4'd0, 1, 4, 1'b0, 1'b0, 1'b0, 1, 32'h0000_00E0, 16'd1024};
    vecs[4] = '{8'h88, 8'hF0, 4'd3, 1, 0, 1'b0, 1'b0, 1'b0, 3, 32'h0080_8088, 16'd0};
    vecs[5] = '{8'h40, 8'h10, 4'd1, 1, 2, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0040, 16'd2048};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; res_ready = 1'b1;
    sig_start = 8'h5A; sig_step = 8'h01; n_pts = 4'd2;
    repeat (3) @(negedge clk);
    #4;
    chk("reset_sigma", sigma_a, 0);
    chk("reset_ctrl", {en_a, fl_a, busy_a, done_a, rv_a}, 0);
    chk("reset_record", {rs_a, re_a}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i], $sformatf("vec%0d", i));
      // One point at strobe period 4: 16 + 4160*4 + 2, less up to 3 cycles of strobe phase.
      if (i == 0) begin
        checks++;
        if (busy_cyc < 16655 || busy_cyc > 16659) begin
          errors++;
          $display("FAIL vec0_busy_len: got %0d cycles, expected 16655..16659", busy_cyc);
        end
      end
    end
    chk("sigma_holds_after_done", sigma_a, 8'h80);

    // Async reset mid-measurement, then a fresh sweep.
    @(negedge clk);
    strobe_per = 1; err_every = 0;
    sig_start = 8'h55; sig_step = 8'h01; n_pts = 4'd2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (16 + 64 + 300) @(negedge clk);
    chk("pre_reset_measuring", {en_a, fl_a, busy_a}, 3'b101);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_sigma", sigma_a, 0);
    chk("async_reset_ctrl", {en_a, fl_a, busy_a, done_a, rv_a}, 0);
    chk("async_reset_record", {rs_a, re_a}, 0);
    q_a.delete();
    fl_run = 0;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(vecs[5], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
